// File: rtl/reg_file_scoreboard.sv
// Architectural register file with a per-register pending-write scoreboard for RAW stall detection.
// Define REGFILE_BYPASS_EN to forward same-cycle writebacks to the read ports and hazard logic.
module reg_file_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WB_en,
   input  logic [DATA_W-1:0] Write_value,
   input  logic [ADDR_W-1:0] Dest,
   input  logic [ADDR_W-1:0] src1,
   input  logic [ADDR_W-1:0] src2,
   output logic [DATA_W-1:0] reg1,
   output logic [DATA_W-1:0] reg2,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_dest,
   input  logic              flush,
   output logic              hazard,
   output logic              sb_full,
   output logic              sb_err
);

   localparam int NREGS = 2**ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [CNT_W-1:0]  cnt_q  [NREGS];
   logic [CNT_W-1:0]  cnt_d  [NREGS];
   logic              sb_err_q, sb_err_d;
   logic [NREGS-1:0]  inc_vec, dec_vec;
   logic              pend1, pend2;

   assign sb_full = (issue_dest != '0) && (cnt_q[issue_dest] == CNT_MAX);
   assign hazard  = pend1 | pend2;
   assign sb_err  = sb_err_q;

   // A flush squashes every in-flight instruction, so neither issues nor retirements count that cycle.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (issue_en && !flush && !sb_full && issue_dest != '0)
         inc_vec[issue_dest] = 1'b1;
      if (WB_en && !flush && Dest != '0)
         dec_vec[Dest] = 1'b1;
   end

   always_comb begin
      regs_d   = regs_q;
      cnt_d    = cnt_q;
      sb_err_d = sb_err_q;
      if (WB_en && Dest != '0)
         regs_d[Dest] = Write_value;
      for (int i = 0; i < NREGS; i++) begin
         if (flush)
            cnt_d[i] = '0;
         else if (inc_vec[i] && !dec_vec[i])
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         else if (dec_vec[i] && !inc_vec[i] && cnt_q[i] != '0)
            cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
      cnt_d[0] = '0;
      // A retirement with no matching issue is a straggler; remember it until reset.
      if (WB_en && !flush && Dest != '0 && cnt_q[Dest] == '0)
         sb_err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         sb_err_q <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         cnt_q    <= cnt_d;
         sb_err_q <= sb_err_d;
      end
   end

   always_comb begin
      reg1 = '0;
      reg2 = '0;
      if (src1 != '0)
         reg1 = (BYPASS && WB_en && Dest == src1) ? Write_value : regs_q[src1];
      if (src2 != '0)
         reg2 = (BYPASS && WB_en && Dest == src2) ? Write_value : regs_q[src2];
   end

   // With bypass, the last outstanding write retiring this cycle is already visible on the read port.
   always_comb begin
      pend1 = (src1 != '0) && (cnt_q[src1] != '0) &&
              !(BYPASS && cnt_q[src1] == CNT_ONE && WB_en && Dest == src1);
      pend2 = (src2 != '0) && (cnt_q[src2] != '0) &&
              !(BYPASS && cnt_q[src2] == CNT_ONE && WB_en && Dest == src2);
   end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: directed vector table, a flush corner sequence, and random traffic vs a model.
// Follows the DUT build: define REGFILE_BYPASS_EN for both when testing the bypass variant.
module tb_reg_file_scoreboard;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic        rst;
      logic        wb_en;
      logic [31:0] wval;
      logic [4:0]  dest;
      logic [4:0]  src1;
      logic [4:0]  src2;
      logic        issue_en;
      logic [4:0]  issue_dest;
      logic        flush;
      logic [31:0] e_reg1;
      logic [31:0] e_reg2;
      logic        e_haz;
      logic        e_full;
      logic        e_err;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        wb_en;
   logic [31:0] write_value;
   logic [4:0]  dest, src1, src2, issue_dest;
   logic [31:0] reg1, reg2;
   logic        issue_en, flush, hazard, sb_full, sb_err;

   int checks;
   int failures;

   vec_t vecs[$];

   logic [31:0] mregs [32];
   int          inflight [32];
   bit          merr;

   reg_file_scoreboard #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .WB_en(wb_en), .Write_value(write_value), .Dest(dest),
      .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2),
      .issue_en(issue_en), .issue_dest(issue_dest), .flush(flush),
      .hazard(hazard), .sb_full(sb_full), .sb_err(sb_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mkVec(logic r, logic we, logic [31:0] wv, logic [4:0] d,
                                  logic [4:0] s1, logic [4:0] s2, logic ie, logic [4:0] id,
                                  logic fl, logic [31:0] er1, logic [31:0] er2,
                                  logic eh, logic ef, logic ee);
      vec_t v;
      v.rst = r; v.wb_en = we; v.wval = wv; v.dest = d; v.src1 = s1; v.src2 = s2;
      v.issue_en = ie; v.issue_dest = id; v.flush = fl;
      v.e_reg1 = er1; v.e_reg2 = er2; v.e_haz = eh; v.e_full = ef; v.e_err = ee;
      return v;
   endfunction

   task automatic addVec(logic r, logic we, logic [31:0] wv, logic [4:0] d,
                         logic [4:0] s1, logic [4:0] s2, logic ie, logic [4:0] id,
                         logic fl, logic [31:0] er1, logic [31:0] er2,
                         logic eh, logic ef, logic ee);
      vecs.push_back(mkVec(r, we, wv, d, s1, s2, ie, id, fl, er1, er2, eh, ef, ee));
   endtask

   task automatic applyStimulus(input vec_t v);
      rst         = v.rst;
      wb_en       = v.wb_en;
      write_value = v.wval;
      dest        = v.dest;
      src1        = v.src1;
      src2        = v.src2;
      issue_en    = v.issue_en;
      issue_dest  = v.issue_dest;
      flush       = v.flush;
   endtask

   task automatic checkOutput(input string tag, input vec_t v);
      checks++;
      if (reg1 !== v.e_reg1) begin
         failures++;
         $display("[TB] FAIL %s reg1 got=%h exp=%h", tag, reg1, v.e_reg1);
      end
      checks++;
      if (reg2 !== v.e_reg2) begin
         failures++;
         $display("[TB] FAIL %s reg2 got=%h exp=%h", tag, reg2, v.e_reg2);
      end
      checks++;
      if (hazard !== v.e_haz) begin
         failures++;
         $display("[TB] FAIL %s hazard got=%b exp=%b", tag, hazard, v.e_haz);
      end
      checks++;
      if (sb_full !== v.e_full) begin
         failures++;
         $display("[TB] FAIL %s sb_full got=%b exp=%b", tag, sb_full, v.e_full);
      end
      checks++;
      if (sb_err !== v.e_err) begin
         failures++;
         $display("[TB] FAIL %s sb_err got=%b exp=%b", tag, sb_err, v.e_err);
      end
   endtask

   // Drive one cycle's inputs, check the combinational outputs mid-cycle, then take the edge.
   task automatic runStep(input vec_t v, input string tag);
      applyStimulus(v);
      #3;
      checkOutput(tag, v);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] modelRead(input vec_t v, input logic [4:0] s);
      if (s == 0) return 32'h0;
      if (BYP && v.wb_en && v.dest == s) return v.wval;
      return mregs[s];
   endfunction

   // A source is waiting while it still has writes in flight, unless the only one lands now with bypass.
   function automatic bit modelPending(input vec_t v, input logic [4:0] s);
      if (s == 0 || inflight[s] == 0) return 1'b0;
      if (BYP && inflight[s] == 1 && v.wb_en && v.dest == s) return 1'b0;
      return 1'b1;
   endfunction

   task automatic modelExpect(inout vec_t v);
      v.e_reg1 = modelRead(v, v.src1);
      v.e_reg2 = modelRead(v, v.src2);
      v.e_haz  = modelPending(v, v.src1) || modelPending(v, v.src2);
      v.e_full = (v.issue_dest != 0) && (inflight[v.issue_dest] == 3);
      v.e_err  = merr;
   endtask

   task automatic modelClear();
      for (int i = 0; i < 32; i++) begin
         mregs[i]    = 32'h0;
         inflight[i] = 0;
      end
      merr = 1'b0;
   endtask

   task automatic modelClock(input vec_t v);
      bit inc, dec;
      if (!v.rst) begin
         modelClear();
         return;
      end
      if (v.wb_en && v.dest != 0) mregs[v.dest] = v.wval;
      if (v.flush) begin
         for (int i = 0; i < 32; i++) inflight[i] = 0;
         return;
      end
      inc = v.issue_en && v.issue_dest != 0 && inflight[v.issue_dest] < 3;
      dec = v.wb_en && v.dest != 0;
      if (dec && inflight[v.dest] == 0) merr = 1'b1;
      if (!(inc && dec && v.issue_dest == v.dest)) begin
         if (inc) inflight[v.issue_dest] = inflight[v.issue_dest] + 1;
         if (dec && inflight[v.dest] > 0) inflight[v.dest] = inflight[v.dest] - 1;
      end
   endtask

   initial begin
      vec_t v;
      checks   = 0;
      failures = 0;

      // rst wb wval dest s1 s2 ie id fl | reg1 reg2 haz full err
      addVec(0, 1, 32'hAAAA, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
      addVec(1, 1, 32'hDEADBEEF, 3, 3, 0, 0, 0, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, !BYP, 0, 0);
      addVec(1, 0, 0, 0, 3, 3, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
      addVec(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 0, 7, 3, 1, 7, 0, 0, 32'hDEADBEEF, 0, 0, 0);
      addVec(1, 0, 0, 0, 7, 3, 1, 7, 0, 0, 32'hDEADBEEF, 1, 0, 0);
      addVec(1, 0, 0, 0, 7, 3, 1, 7, 0, 0, 32'hDEADBEEF, 1, 0, 0);
      addVec(1, 0, 0, 0, 7, 3, 1, 7, 0, 0, 32'hDEADBEEF, 1, 1, 0);
      addVec(1, 1, 32'h77, 7, 7, 3, 0, 7, 0, BYP ? 32'h77 : 32'h0, 32'hDEADBEEF, 1, 1, 0);
      addVec(1, 1, 32'h78, 7, 7, 3, 0, 7, 0, BYP ? 32'h78 : 32'h77, 32'hDEADBEEF, 1, 0, 0);
      addVec(1, 1, 32'h79, 7, 7, 3, 0, 7, 0, BYP ? 32'h79 : 32'h78, 32'hDEADBEEF, !BYP, 0, 0);
      addVec(1, 0, 0, 0, 7, 3, 0, 7, 0, 32'h79, 32'hDEADBEEF, 0, 0, 0);
      addVec(1, 0, 0, 0, 9, 0, 1, 9, 0, 0, 0, 0, 0, 0);
      addVec(1, 1, 32'h99, 9, 9, 0, 1, 9, 0, BYP ? 32'h99 : 32'h0, 0, !BYP, 0, 0);
      addVec(1, 0, 0, 0, 9, 0, 0, 0, 0, 32'h99, 0, 1, 0, 0);
      addVec(1, 1, 32'h9A, 9, 9, 0, 0, 0, 0, BYP ? 32'h9A : 32'h99, 0, !BYP, 0, 0);
      addVec(1, 0, 0, 0, 9, 0, 0, 0, 0, 32'h9A, 0, 0, 0, 0);
      addVec(1, 0, 0, 0, 9, 4, 1, 4, 0, 32'h9A, 0, 0, 0, 0);
      addVec(1, 0, 0, 0, 9, 4, 1, 4, 0, 32'h9A, 0, 1, 0, 0);
      addVec(1, 0, 0, 0, 9, 4, 0, 0, 1, 32'h9A, 0, 1, 0, 0);
      addVec(1, 0, 0, 0, 9, 4, 0, 0, 0, 32'h9A, 0, 0, 0, 0);
      addVec(1, 1, 32'h44, 4, 9, 4, 0, 0, 0, 32'h9A, BYP ? 32'h44 : 32'h0, 0, 0, 0);
      addVec(1, 0, 0, 0, 9, 4, 0, 0, 0, 32'h9A, 32'h44, 0, 0, 1);
      addVec(0, 1, 32'h55, 4, 2, 4, 1, 2, 1, 0, BYP ? 32'h55 : 32'h44, 0, 0, 1);
      addVec(1, 0, 0, 0, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 0, 9, 3, 0, 0, 0, 0, 0, 0, 0, 0);

      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++)
         runStep(vecs[i], $sformatf("vec%0d", i));

      // Flush while the counter is saturated, with an issue and a writeback to the same register.
      runStep(mkVec(1, 0, 0, 0, 12, 0, 1, 12, 0, 0, 0, 0, 0, 0), "fl_issue1");
      runStep(mkVec(1, 0, 0, 0, 12, 0, 1, 12, 0, 0, 0, 1, 0, 0), "fl_issue2");
      runStep(mkVec(1, 0, 0, 0, 12, 0, 1, 12, 0, 0, 0, 1, 0, 0), "fl_issue3");
      runStep(mkVec(1, 1, 32'hC0FFEE, 12, 12, 0, 1, 12, 1,
                    BYP ? 32'hC0FFEE : 32'h0, 0, 1, 1, 0), "fl_flush");
      runStep(mkVec(1, 0, 0, 0, 12, 0, 0, 12, 0, 32'hC0FFEE, 0, 0, 0, 0), "fl_after");

      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      modelClear();

      for (int n = 0; n < 600; n++) begin
         v = mkVec($urandom_range(0, 59) != 0, $urandom_range(0, 1), $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)),
                   $urandom_range(0, 24) == 0, 0, 0, 0, 0, 0);
         modelExpect(v);
         runStep(v, $sformatf("rnd%0d", n));
         modelClock(v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
